// File: rtl/udp_pkg.sv
// Shared Ethernet receive constants, framer state type and MAC byte helper.
package udp_pkg;

    localparam logic [7:0]  ETH_PREAMBLE  = 8'h55;
    localparam logic [7:0]  ETH_SFD       = 8'hD5;
    localparam int unsigned ETH_HDR_LEN   = 14;
    localparam int unsigned ETH_FCS_LEN   = 4;
    localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
    localparam logic [47:0] BCAST_MAC     = 48'hFFFF_FFFF_FFFF;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        HEADER,
        PAYLOAD,
        DISCARD
    } rx_state_t;

    // Byte idx of an address in wire order (idx 0 = most significant byte).
    function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [3:0] idx);
        logic [47:0] shifted;
        shifted = mac << {idx, 3'b000};
        return shifted[47:40];
    endfunction

endpackage

// File: rtl/eth_rx_delay_line.sv
// Byte shift register with occupancy count; newest byte at mem[0], oldest at mem[count-1].
module eth_rx_delay_line #(
    parameter int unsigned DEPTH = 5,
    parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          clear,
    input  logic [7:0]    din,
    output logic [7:0]    dout,
    output logic [CW-1:0] count
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[0] <= din;
                for (int unsigned i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
            end
            // A push into a full line without pop discards the oldest entry.
            if (clear)
                count <= '0;
            else if (push && !pop && count != CW'(DEPTH))
                count <= count + 1'b1;
            else if (pop && !push && count != '0)
                count <= count - 1'b1;
        end
    end

    always_comb begin
        dout = '0;
        for (int unsigned i = 0; i < DEPTH; i++)
            if (count == CW'(i + 1)) dout = mem[i];
    end

endmodule

// File: rtl/eth_rx_framer.sv
// Ethernet receive framer: strips preamble/SFD, filters dst MAC and EtherType, strips header and FCS.
// Define ETH_RX_BCAST_EN to also accept frames addressed to the broadcast MAC.
module eth_rx_framer
    import udp_pkg::*;
#(
    parameter logic [47:0] MAC_ADDR = 48'h02_00_00_00_00_01,
    parameter int unsigned PRE_MIN  = 6,
    parameter int unsigned MAX_LEN  = 1504
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_dv,
    input  logic        rx_er,
    output logic [7:0]  udp_rx,
    output logic        udp_rx_valid,
    output logic        udp_rx_first,
    output logic        udp_rx_last,
    output logic        udp_rx_abort,
    output logic [15:0] drop_cnt
);

    localparam int unsigned DL_DEPTH = ETH_FCS_LEN + 1;
    localparam int unsigned DL_CW    = $clog2(DL_DEPTH + 1);
    localparam logic [3:0]  HDR_LAST = 4'(ETH_HDR_LEN - 1);

    rx_state_t        state, state_nxt;
    logic [3:0]       pcnt, hcnt;
    logic [15:0]      byte_cnt;
    logic             first_sent;
    logic             ucast_miss, ucast_miss_nxt;
    logic             type_miss, type_miss_nxt;
    logic             hdr_accept, hdr_last, sfd_ok, len_over;
    logic             dl_push, dl_pop, dl_clear, dl_full;
    logic [7:0]       dl_dout;
    logic [DL_CW-1:0] dl_count;
    logic             emit, emit_last, abort_nxt, drop_inc;

    eth_rx_delay_line #(.DEPTH(DL_DEPTH), .CW(DL_CW)) u_dl (
        .clk   (clk),
        .rst   (rst),
        .push  (dl_push),
        .pop   (dl_pop),
        .clear (dl_clear),
        .din   (rx_data),
        .dout  (dl_dout),
        .count (dl_count)
    );

    assign dl_full  = (dl_count == DL_CW'(DL_DEPTH));
    assign hdr_last = (hcnt == HDR_LAST);
    assign sfd_ok   = (rx_data == ETH_SFD) && (32'(pcnt) >= PRE_MIN);
    assign len_over = (32'(byte_cnt) == MAX_LEN);

    // Address/type misses accumulate over the header; the current byte is folded in for the decision at byte 13.
    always_comb begin
        ucast_miss_nxt = ucast_miss;
        type_miss_nxt  = type_miss;
        if (hcnt < 4'd6 && rx_data != mac_byte(MAC_ADDR, hcnt)) ucast_miss_nxt = 1'b1;
        if (hcnt == 4'd12 && rx_data != ETH_TYPE_IPV4[15:8])    type_miss_nxt  = 1'b1;
        if (hdr_last && rx_data != ETH_TYPE_IPV4[7:0])          type_miss_nxt  = 1'b1;
    end

`ifdef ETH_RX_BCAST_EN
    logic bcast_miss, bcast_miss_nxt;

    always_comb begin
        bcast_miss_nxt = bcast_miss;
        if (hcnt < 4'd6 && rx_data != BCAST_MAC[47:40]) bcast_miss_nxt = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  bcast_miss <= 1'b0;
        else if (state != HEADER) bcast_miss <= 1'b0;
        else                      bcast_miss <= bcast_miss_nxt;
    end

    assign hdr_accept = !type_miss_nxt && (!ucast_miss_nxt || !bcast_miss_nxt);
`else
    assign hdr_accept = !type_miss_nxt && !ucast_miss_nxt;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:
                if (rx_dv) state_nxt = (rx_data == ETH_PREAMBLE) ? PREAMBLE : DISCARD;
            PREAMBLE:
                if (!rx_dv)                       state_nxt = IDLE;
                else if (rx_data == ETH_PREAMBLE) state_nxt = PREAMBLE;
                else if (sfd_ok)                  state_nxt = HEADER;
                else                              state_nxt = DISCARD;
            HEADER:
                if (!rx_dv)        state_nxt = IDLE;
                else if (rx_er)    state_nxt = DISCARD;
                else if (hdr_last) state_nxt = hdr_accept ? PAYLOAD : DISCARD;
            PAYLOAD:
                if (!rx_dv)                   state_nxt = IDLE;
                else if (rx_er || len_over)   state_nxt = DISCARD;
            DISCARD:
                if (!rx_dv) state_nxt = IDLE;
            default:
                state_nxt = IDLE;
        endcase
    end

    always_comb begin
        dl_push   = 1'b0;
        dl_pop    = 1'b0;
        dl_clear  = 1'b0;
        emit      = 1'b0;
        emit_last = 1'b0;
        abort_nxt = 1'b0;
        drop_inc  = 1'b0;
        case (state)
            HEADER:
                if (!rx_dv || rx_er || (hdr_last && !hdr_accept)) drop_inc = 1'b1;
            PAYLOAD:
                if (!rx_dv) begin
                    dl_clear = 1'b1;
                    if (dl_full) begin
                        emit      = 1'b1;
                        emit_last = 1'b1;
                    end else begin
                        drop_inc  = 1'b1;
                    end
                end else if (rx_er || len_over) begin
                    dl_clear  = 1'b1;
                    drop_inc  = 1'b1;
                    abort_nxt = first_sent;
                end else begin
                    dl_push = 1'b1;
                    if (dl_full) begin
                        dl_pop = 1'b1;
                        emit   = 1'b1;
                    end
                end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt         <= '0;
            hcnt         <= '0;
            byte_cnt     <= '0;
            first_sent   <= 1'b0;
            ucast_miss   <= 1'b0;
            type_miss    <= 1'b0;
            udp_rx       <= '0;
            udp_rx_valid <= 1'b0;
            udp_rx_first <= 1'b0;
            udp_rx_last  <= 1'b0;
            udp_rx_abort <= 1'b0;
            drop_cnt     <= '0;
        end else begin
            if (state == IDLE)
                pcnt <= 4'd1;
            else if (state == PREAMBLE && rx_data == ETH_PREAMBLE && pcnt != 4'hF)
                pcnt <= pcnt + 4'd1;

            if (state != HEADER) begin
                hcnt       <= '0;
                ucast_miss <= 1'b0;
                type_miss  <= 1'b0;
            end else begin
                hcnt       <= hcnt + 4'd1;
                ucast_miss <= ucast_miss_nxt;
                type_miss  <= type_miss_nxt;
            end

            if (state != PAYLOAD) byte_cnt <= '0;
            else if (dl_push)     byte_cnt <= byte_cnt + 16'd1;

            if (state_nxt != PAYLOAD) first_sent <= 1'b0;
            else if (emit)            first_sent <= 1'b1;

            udp_rx       <= emit ? dl_dout : '0;
            udp_rx_valid <= emit;
            udp_rx_first <= emit && !first_sent;
            udp_rx_last  <= emit_last;
            udp_rx_abort <= abort_nxt;

            if (drop_inc && drop_cnt != '1) drop_cnt <= drop_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_eth_rx_framer.sv
// Self-checking bench for eth_rx_framer: directed and random frames against a frame-level reference model.
module tb_eth_rx_framer;

    localparam logic [47:0] MAC     = 48'h02_00_00_00_00_01;
    localparam int          PRE_MIN = 6;
    localparam int          MAX_LEN = 1504;
`ifdef ETH_RX_BCAST_EN
    localparam bit BCAST_EN = 1'b1;
`else
    localparam bit BCAST_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_dv;
    logic        rx_er;
    logic [7:0]  udp_rx;
    logic        udp_rx_valid, udp_rx_first, udp_rx_last, udp_rx_abort;
    logic [15:0] drop_cnt;

    eth_rx_framer #(.MAC_ADDR(MAC), .PRE_MIN(PRE_MIN), .MAX_LEN(MAX_LEN)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data      (rx_data),
        .rx_dv        (rx_dv),
        .rx_er        (rx_er),
        .udp_rx       (udp_rx),
        .udp_rx_valid (udp_rx_valid),
        .udp_rx_first (udp_rx_first),
        .udp_rx_last  (udp_rx_last),
        .udp_rx_abort (udp_rx_abort),
        .drop_cnt     (drop_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] got_q[$];
    logic [31:0] exp_q[$];
    logic [7:0]  frm[$];
    int n_checks = 0, n_errors = 0, exp_drop = 0;
    int mark_idx = -1, t_in = 0, t_out = 0;

    function automatic logic [31:0] item(input bit v, input bit a, input bit f, input bit l, input logic [7:0] d);
        return {20'd0, v, a, f, l, d};
    endfunction

    always @(negedge clk) begin
        if (!rst && (udp_rx_valid || udp_rx_abort || udp_rx_first || udp_rx_last)) begin
            got_q.push_back(item(udp_rx_valid, udp_rx_abort, udp_rx_first, udp_rx_last, udp_rx));
            if (udp_rx_valid && udp_rx_first) t_out = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic build(input int npre, input logic [7:0] sfd, input logic [47:0] dst,
                         input logic [15:0] ty, input int plen, input int nfcs, input bit seq);
        frm.delete();
        repeat (npre) frm.push_back(8'h55);
        frm.push_back(sfd);
        for (int i = 0; i < 6; i++) frm.push_back(dst[8*(5-i) +: 8]);
        for (int i = 0; i < 6; i++) frm.push_back(8'($urandom));
        frm.push_back(ty[15:8]);
        frm.push_back(ty[7:0]);
        for (int i = 0; i < plen; i++) frm.push_back(seq ? 8'(i + 1) : 8'($urandom));
        for (int i = 0; i < nfcs; i++) frm.push_back(8'($urandom));
    endtask

    // Frame-level expectation: what reaches udpip_rx and whether the frame counts as dropped.
    task automatic model(input int er);
        int n, hdr, ps, np, e, k;
        logic [47:0] dst;
        logic [15:0] ty;
        n = 0;
        while (n < frm.size() && frm[n] == 8'h55) n++;
        if (n < PRE_MIN || n >= frm.size() || frm[n] != 8'hD5) return;
        hdr = n + 1;
        ps  = hdr + 14;
        if (frm.size() < ps || (er >= hdr && er < ps)) begin
            exp_drop++;
            return;
        end
        dst = '0;
        for (int i = 0; i < 6; i++) dst = {dst[39:0], frm[hdr+i]};
        ty = {frm[hdr+12], frm[hdr+13]};
        if (ty != 16'h0800 || !(dst == MAC || (BCAST_EN && dst == '1))) begin
            exp_drop++;
            return;
        end
        np = frm.size() - ps;
        e  = (er >= ps) ? er - ps : -1;
        if (np > MAX_LEN && (e < 0 || e > MAX_LEN)) e = MAX_LEN;
        if (e >= 0) begin
            k = (e > 5) ? e - 5 : 0;
            for (int i = 0; i < k; i++) exp_q.push_back(item(1, 0, i == 0, 0, frm[ps+i]));
            if (k > 0) exp_q.push_back(item(0, 1, 0, 0, 8'h00));
            exp_drop++;
        end else if (np < 5) begin
            exp_drop++;
        end else begin
            for (int i = 0; i < np - 4; i++) exp_q.push_back(item(1, 0, i == 0, i == np - 5, frm[ps+i]));
        end
    endtask

    task automatic send(input int er, input int gap);
        for (int i = 0; i < frm.size(); i++) begin
            @(negedge clk);
            rx_dv   = 1'b1;
            rx_data = frm[i];
            rx_er   = (i == er);
            if (i == mark_idx) t_in = cyc;
        end
        repeat (gap) begin
            @(negedge clk);
            rx_dv   = 1'b0;
            rx_data = 8'h00;
            rx_er   = 1'b0;
        end
    endtask

    task automatic run(input int er, input int gap);
        model(er);
        send(er, gap);
    endtask

    task automatic drain_check(input string tag);
        int n;
        rx_dv   = 1'b0;
        rx_er   = 1'b0;
        rx_data = 8'h00;
        repeat (12) @(negedge clk);
        check({tag, " count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check({tag, " item"}, got_q[i], exp_q[i]);
        check({tag, " drop_cnt"}, 32'(drop_cnt), exp_drop);
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int kind, plen, npre, er, gap, b;
        logic [47:0] dst;
        logic [15:0] ty;

        rst = 1'b1; rx_dv = 1'b0; rx_data = 8'h00; rx_er = 1'b0;
        repeat (3) @(negedge clk);
        check("reset outputs", {udp_rx, udp_rx_valid, udp_rx_first, udp_rx_last, udp_rx_abort, drop_cnt}, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 1: nominal frame, 28-byte payload, latency
        build(7, 8'hD5, MAC, 16'h0800, 28, 4, 1);
        mark_idx = 7 + 15;
        run(-1, 1);
        mark_idx = -1;
        drain_check("t1");
        check("t1 latency", t_out - t_in, 6);

        // 2: wrong destination, broadcast
        build(7, 8'hD5, 48'h02_00_00_00_00_02, 16'h0800, 28, 4, 1);
        run(-1, 1);
        drain_check("t2 dst");
        build(7, 8'hD5, 48'hFFFF_FFFF_FFFF, 16'h0800, 28, 4, 1);
        run(-1, 1);
        drain_check("t2 bcast");

        // 3: wrong EtherType followed by a good frame after one idle cycle
        build(7, 8'hD5, MAC, 16'h86DD, 28, 4, 1);
        run(-1, 1);
        build(7, 8'hD5, MAC, 16'h0800, 28, 4, 0);
        run(-1, 1);
        drain_check("t3");

        // 4: rx_er on payload byte 10
        build(7, 8'hD5, MAC, 16'h0800, 28, 4, 1);
        run(7 + 15 + 9, 1);
        drain_check("t4");

        // 5: single-byte payload, then 3-byte runt
        build(7, 8'hD5, MAC, 16'h0800, 1, 4, 0);
        frm[7 + 15] = 8'hAA;
        run(-1, 1);
        drain_check("t5 one");
        build(7, 8'hD5, MAC, 16'h0800, 0, 3, 0);
        run(-1, 1);
        drain_check("t5 runt");

        // back-to-back deliverable frames, last emission overlapping next preamble
        build(7, 8'hD5, MAC, 16'h0800, 9, 4, 0);
        run(-1, 1);
        build(6, 8'hD5, MAC, 16'h0800, 3, 4, 0);
        run(-1, 1);
        drain_check("b2b");

        // preamble boundaries: PRE_MIN-1 (silently ignored), long saturating preamble
        build(PRE_MIN - 1, 8'hD5, MAC, 16'h0800, 8, 4, 0);
        run(-1, 1);
        build(20, 8'hD5, MAC, 16'h0800, 8, 4, 0);
        run(-1, 1);
        drain_check("preamble");

        // header truncated by rx_dv, header rx_er
        build(7, 8'hD5, MAC, 16'h0800, 8, 4, 0);
        while (frm.size() > 16) void'(frm.pop_back());
        run(-1, 1);
        build(7, 8'hD5, MAC, 16'h0800, 8, 4, 0);
        run(7 + 1 + 13, 1);
        drain_check("hdr err");

        // length limit: exactly MAX_LEN accepted, one more aborts
        build(7, 8'hD5, MAC, 16'h0800, MAX_LEN - 4, 4, 0);
        run(-1, 1);
        drain_check("maxlen ok");
        build(7, 8'hD5, MAC, 16'h0800, MAX_LEN - 3, 4, 0);
        run(-1, 1);
        drain_check("maxlen over");

        for (int r = 0; r < 40; r++) begin
            kind = $urandom_range(0, 7);
            plen = $urandom_range(0, 60);
            npre = $urandom_range(1, 20);
            gap  = $urandom_range(1, 3);
            er   = -1;
            dst  = MAC;
            ty   = 16'h0800;
            case (kind)
                1: begin b = $urandom_range(0, 47); dst[b] = ~dst[b]; end
                2: dst = 48'hFFFF_FFFF_FFFF;
                3: ty = 16'h86DD;
                4: er = npre + 15 + $urandom_range(0, plen + 3);
                5: er = npre + 1 + $urandom_range(0, 13);
                6: plen = 0;
                default: ;
            endcase
            build(npre, 8'hD5, dst, ty, plen, (kind == 6) ? $urandom_range(0, 4) : 4, 0);
            run(er, gap);
            drain_check("rand");
        end

        // 6: reset during payload byte 15
        build(7, 8'hD5, MAC, 16'h0800, 28, 4, 1);
        for (int i = 0; i < 7 + 15 + 14; i++) begin
            @(negedge clk);
            rx_dv   = 1'b1;
            rx_data = frm[i];
            rx_er   = 1'b0;
        end
        @(negedge clk);
        rx_data = frm[7 + 15 + 14];
        for (int i = 0; i < 9; i++) exp_q.push_back(item(1, 0, i == 0, 0, 8'(i + 1)));
        #2 rst = 1'b1;
        #1;
        check("t6 rst outputs", {udp_rx, udp_rx_valid, udp_rx_first, udp_rx_last, udp_rx_abort, drop_cnt}, 0);
        exp_drop = 0;
        @(negedge clk);
        rx_dv   = 1'b0;
        rx_data = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        drain_check("t6");
        build(7, 8'hD5, MAC, 16'h0800, 20, 4, 0);
        run(-1, 1);
        drain_check("t6 after");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/eth_rx_framer.md
Name: eth_rx_framer

Overview:
Receive-side Ethernet framer that sits directly upstream of udpip_rx.
- Takes the raw byte stream from the PHY/MAC byte interface and strips preamble/SFD.
- Filters on destination MAC and EtherType (IPv4), then strips the 14-byte Ethernet header and the 4-byte FCS.
- Emits the IP/UDP payload as a byte stream with valid/first/last framing, matching udpip_rx's input handshake.

Parameters:
MAC_ADDR, 48'h02_00_00_00_00_01, local station address; byte 0 on the wire = MAC_ADDR[47:40]
PRE_MIN, 6, minimum count of 0x55 bytes required before SFD
MAX_LEN, 1504, maximum payload+FCS bytes after header; exceeding it aborts the frame

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous active-high reset
rx_data  in  8  PHY byte
rx_dv  in  1  PHY data valid; high for whole frame, one byte per cycle
rx_er  in  1  PHY error flag, qualified by rx_dv
udp_rx  out  8  payload byte to udpip_rx
udp_rx_valid  out  1  udp_rx carries a payload byte this cycle
udp_rx_first  out  1  with valid: first payload byte of frame
udp_rx_last  out  1  with valid: final payload byte of frame
udp_rx_abort  out  1  one-cycle pulse: frame already started downstream was cancelled
drop_cnt  out  16  saturating count of dropped frames

Behaviour:
- Reset: all outputs 0, drop_cnt 0, state IDLE, delay line empty, no abort pulse for any partial frame.
- All outputs are registered.
- States:
  - IDLE: rx_dv=1 and rx_data=0x55 -> PREAMBLE with pcnt=1. rx_dv=1 with any other byte -> DISCARD.
  - PREAMBLE:
    - 0x55 -> pcnt++, saturating at 15.
    - 0xD5 with pcnt>=PRE_MIN -> HEADER with hcnt=0.
    - 0xD5 with pcnt<PRE_MIN, or any other byte -> DISCARD.
    - rx_dv=0 -> IDLE. Preamble failures are not counted in drop_cnt.
  - HEADER: 14 bytes, hcnt 0..13.
    - Bytes 0-5 compared to MAC_ADDR.
    - Bytes 12-13 must equal 0x08,0x00.
    - Mismatch is decided at hcnt=13 -> DISCARD, drop_cnt++.
    - rx_dv=0 or rx_er=1 before hcnt=13 -> drop_cnt++, then IDLE or DISCARD respectively.
  - PAYLOAD: each byte is pushed into a 5-deep byte delay line.
    - When a byte is pushed and the line already holds 5, the oldest byte is emitted with udp_rx_valid=1 one cycle later.
    - udp_rx_first=1 on the first emission of the frame.
    - The 4 FCS bytes plus 1 byte of look-ahead remain in the line.
  - DISCARD: ignore input until rx_dv=0 -> IDLE.
- End of frame (rx_dv falls in PAYLOAD):
  - Bytes received >=5: the oldest held byte is emitted next cycle with valid=1 and last=1. It also carries first=1 if it is the only payload byte.
  - Bytes received <5: runt, no emission, drop_cnt++.
  - In both cases the delay line is cleared and the state goes to IDLE.
- Errors in PAYLOAD (rx_er=1, or byte count reaches MAX_LEN+1):
  - If first has already been emitted, pulse udp_rx_abort for 1 cycle with valid=0 and no last.
  - Always drop_cnt++ and go to DISCARD.
- Latency: payload byte k appears 6 cycles after it arrives on rx_data (5 bytes of delay plus the output register). Output is gap-free while the input is gap-free.
- Back-to-back frames: 1 idle rx_dv cycle minimum. A last emission and a new frame's preamble in the same cycle must both be handled.
- The FCS is not checked; CRC validation stays downstream.
- drop_cnt holds at 16'hFFFF.

Optional Feature:
ETH_RX_BCAST_EN: when defined, a destination of FF:FF:FF:FF:FF:FF is accepted in addition to MAC_ADDR. When undefined, only an exact MAC_ADDR match is accepted and broadcast frames are dropped and counted.

Decomposition:
Package udp_pkg holds:
- ETH_PREAMBLE=8'h55, ETH_SFD=8'hD5
- ETH_HDR_LEN=14, ETH_FCS_LEN=4
- ETH_TYPE_IPV4=16'h0800
- BCAST_MAC=48'hFFFF_FFFF_FFFF
- the rx state enum (IDLE, PREAMBLE, HEADER, PAYLOAD, DISCARD)

Sub-module eth_rx_delay_line: 5-deep byte shift register with occupancy count, push/pop/clear, oldest-byte output. The framer FSM, filters and counters stay in the top module.

Test Plan:
1. 7x55, D5, dst=MAC_ADDR, src=any, type 0800, payload 01..1C (28 B), 4 FCS bytes -> 28 valid cycles carrying 01..1C, first on 01, last on 1C, no FCS bytes out, drop_cnt=0, first output 6 cycles after byte 01 arrives.
2. Same frame with dst=02_00_00_00_00_02 -> no valid output, drop_cnt=1. Dst FF..FF -> dropped when ETH_RX_BCAST_EN is undefined, delivered when defined.
3. Type 86DD -> dropped, drop_cnt=1. A following valid frame after a 1-cycle rx_dv gap -> delivered intact.
4. rx_er asserted on payload byte 10 of 28 -> bytes 01..04 emitted, then udp_rx_abort pulses 1 cycle, no last, drop_cnt=1.
5. Payload of 1 byte (AA) plus 4 FCS -> single output AA with first=1 and last=1. Payload 0 bytes + 3 FCS -> no output, drop_cnt=1.
6. rst asserted during payload byte 15 -> all outputs 0 immediately, no abort or last pulse. Next good frame delivered correctly with first=1.
